// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Load/store sequencer sitting directly in front of a 64x16 RAM with a
// one-cycle registered read. One request (LOAD, STORE, MOVE) is in flight at
// a time; each accepted request produces exactly one response. MOVE copies
// mem[src] to mem[dst] with a read, a capture and a write.
module ram_access_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [DATA_W-1:0] req_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  // RAM side
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  // statistics
  output logic [CNT_W-1:0]  txn_count
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // RD  : RAM read strobe issued
  // CAP : registered RAM data is valid, captured into data_q
  // WR  : RAM write strobe issued (STORE, second half of MOVE)
  // RSP : response held until the consumer takes it
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          op_q, op_next;
  logic [ADDR_W-1:0]   addr_q, addr_next;
  logic [ADDR_W-1:0]   dst_q, dst_next;
  logic [DATA_W-1:0]   data_q, data_next;
  logic                err_q, err_next;
  logic [CNT_W-1:0]    txn_q, txn_next;

  // State and datapath registers; an asynchronous reset drops any in-flight
  // request, so a pending write never reaches the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      txn_q     <= '0;
    end else begin
      state_reg <= state_next;
      op_q      <= op_next;
      addr_q    <= addr_next;
      dst_q     <= dst_next;
      data_q    <= data_next;
      err_q     <= err_next;
      txn_q     <= txn_next;
    end
  end

  // Next-state, register updates and strobes decoded from the current state.
  always_comb begin
    state_next = state_reg;
    op_next    = op_q;
    addr_next  = addr_q;
    dst_next   = dst_q;
    data_next  = data_q;
    err_next   = err_q;
    txn_next   = txn_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ram_read   = 1'b0;
    ram_write  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_next   = req_op;
          addr_next = req_addr;
          dst_next  = req_dst;
          unique case (req_op)
            OP_LOAD, OP_MOVE: begin
              state_next = RD;
            end
            OP_STORE: begin
              data_next  = req_wdata;
              state_next = WR;
            end
            default: begin
              // Reserved opcode: answer immediately with an error, touch no RAM.
              data_next  = '0;
              err_next   = 1'b1;
              state_next = RSP;
            end
          endcase
        end
      end

      RD: begin
        ram_read   = 1'b1;
        state_next = CAP;
      end

      CAP: begin
        data_next  = ram_data_out;
        state_next = (op_q == OP_MOVE) ? WR : RSP;
      end

      WR: begin
        ram_write  = 1'b1;
        state_next = RSP;
      end

      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          txn_next   = txn_q + CNT_ONE;
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RAM addresses and write data always come straight from registers so the
  // RAM never sees X, even while its strobes are low.
  assign ram_read_addr  = addr_q;
  assign ram_write_addr = (op_q == OP_MOVE) ? dst_q : addr_q;
  assign ram_data_in    = data_q;

  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Drives the controller against a behavioural 64x16 RAM with registered read,
// and checks responses, latencies, RAM strobe counts and the transaction
// counter against an array-based model of memory contents.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [5:0]  req_addr;
  logic [5:0]  req_dst;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        ram_read;
  logic        ram_write;
  logic [5:0]  ram_read_addr;
  logic [5:0]  ram_write_addr;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;
  logic [7:0]  txn_count;

  int checks   = 0;
  int failures = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  // reference model state
  logic [15:0] ref_mem [64];
  logic [7:0]  exp_txn;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_W(6), .DATA_W(16), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_dst        (req_dst),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .ram_read       (ram_read),
    .ram_write      (ram_write),
    .ram_read_addr  (ram_read_addr),
    .ram_write_addr (ram_write_addr),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out),
    .txn_count      (txn_count)
  );

  // behavioural RAM: 64x16, registered read, contents survive reset
  logic [15:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_write_addr] <= ram_data_in;
    if (ram_read)  ram_data_out <= ram_mem[ram_read_addr];
  end

  // strobe counters
  always @(posedge clk) begin
    if (ram_write) wr_pulses++;
    if (ram_read)  rd_pulses++;
  end

  // the RAM must never be read and written in the same cycle
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ((ram_read && ram_write) !== 1'b0) begin
        failures++;
        $display("FAIL rd_wr_same_cycle t=%0t read=%b write=%b required not both 1", $time, ram_read, ram_write);
      end
    end
  end

  // Issue one request and complete its response after 'hold' cycles of
  // back-pressure. Called and returns at 1ns after a rising edge.
  task automatic send(input logic [1:0] op, input logic [5:0] a, input logic [5:0] d,
                      input logic [15:0] wd, input int hold,
                      output logic [15:0] rd, output logic re, output int lat);
    int n;
    req_op = op; req_addr = a; req_dst = d; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout op=%0d req_ready=%b required 1 within 20 cycles", op, req_ready);
      req_valid = 1'b0; rd = '0; re = 1'b0; lat = -1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    if (rsp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL rsp_timeout op=%0d rsp_valid=%b required 1 within 20 cycles", op, rsp_valid);
      rd = '0; re = 1'b0; lat = -1;
      return;
    end
    rd = rsp_data; re = rsp_err;
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 8'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_addr = '0; req_dst = '0; req_wdata = '0;
    exp_txn = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, ram_read, ram_write} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl ready/rspv/rd/wr=%b required 1000", {req_ready, rsp_valid, ram_read, ram_write});
    end
    checks++;
    if ({ram_read_addr, ram_write_addr, ram_data_in, rsp_data, rsp_err, txn_count} !== '0) begin
      failures++;
      $display("FAIL reset_data raddr=%h waddr=%h din=%h rdata=%h err=%b cnt=%0d required all 0",
               ram_read_addr, ram_write_addr, ram_data_in, rsp_data, rsp_err, txn_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // write every address once so the model knows all RAM contents
  task automatic test_fill();
    logic [15:0] rd; logic re; int lat; logic [15:0] wd;
    for (int a = 0; a < 64; a++) begin
      wd = 16'($urandom);
      send(2'b01, 6'(a), 6'd0, wd, 0, rd, re, lat);
      ref_mem[a] = wd;
      checks++;
      if (rd !== wd || re !== 1'b0 || lat != 2) begin
        failures++;
        $display("FAIL fill_store addr=%0d data=%h err=%b lat=%0d required data=%h err=0 lat=2", a, rd, re, lat, wd);
      end
    end
    checks++;
    if (txn_count !== exp_txn) begin
      failures++;
      $display("FAIL fill_count txn_count=%0d required %0d", txn_count, exp_txn);
    end
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic re; int lat;
    send(2'b01, 6'd63, 6'd0, 16'hBEEF, 0, rd, re, lat);
    ref_mem[63] = 16'hBEEF;
    send(2'b00, 6'd63, 6'd0, 16'h0000, 0, rd, re, lat);
    checks++;
    if (rd !== 16'hBEEF || re !== 1'b0 || lat != 3) begin
      failures++;
      $display("FAIL store_load63 data=%h err=%b lat=%0d required data=beef err=0 lat=3", rd, re, lat);
    end
  endtask

  task automatic test_move();
    logic [15:0] rd; logic re; int lat; int w0; logic [15:0] exp61;
    send(2'b01, 6'd62, 6'd0, 16'h1234, 0, rd, re, lat);
    ref_mem[62] = 16'h1234;
    w0 = wr_pulses;
    send(2'b10, 6'd62, 6'd60, 16'hFFFF, 0, rd, re, lat);
    ref_mem[60] = ref_mem[62];
    checks++;
    if (rd !== 16'h1234 || re !== 1'b0 || lat != 4 || (wr_pulses - w0) != 1) begin
      failures++;
      $display("FAIL move_b_to_d data=%h err=%b lat=%0d writes=%0d required data=1234 err=0 lat=4 writes=1",
               rd, re, lat, wr_pulses - w0);
    end
    send(2'b00, 6'd60, 6'd0, 16'h0000, 0, rd, re, lat);
    checks++;
    if (rd !== 16'h1234 || re !== 1'b0) begin
      failures++;
      $display("FAIL move_load60 data=%h err=%b required data=1234 err=0", rd, re);
    end
    // src == dst rewrites the same value
    exp61 = ref_mem[61];
    send(2'b10, 6'd61, 6'd61, 16'h0000, 0, rd, re, lat);
    send(2'b00, 6'd61, 6'd0, 16'h0000, 0, rd, re, lat);
    checks++;
    if (rd !== exp61) begin
      failures++;
      $display("FAIL move_self data=%h required %h", rd, exp61);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held; int lat;
    req_op = 2'b00; req_addr = 6'd10; req_dst = '0; req_wdata = '0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (rsp_valid !== 1'b1 || lat != 3 || rsp_data !== ref_mem[10]) begin
      failures++;
      $display("FAIL bp_first rsp_valid=%b lat=%0d data=%h required valid=1 lat=3 data=%h", rsp_valid, lat, rsp_data, ref_mem[10]);
    end
    held = rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b data=%h ready=%b required valid=1 data=%h ready=0", i, rsp_valid, rsp_data, req_ready, held);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 8'd1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || txn_count !== exp_txn) begin
      failures++;
      $display("FAIL bp_release valid=%b ready=%b cnt=%0d required valid=0 ready=1 cnt=%0d", rsp_valid, req_ready, txn_count, exp_txn);
    end
  endtask

  task automatic test_reserved();
    logic [15:0] rd; logic re; int lat; int w0; int r0;
    w0 = wr_pulses; r0 = rd_pulses;
    send(2'b11, 6'd5, 6'd9, 16'hA5A5, 0, rd, re, lat);
    checks++;
    if (rd !== 16'h0000 || re !== 1'b1 || lat != 1 || (wr_pulses - w0) != 0 || (rd_pulses - r0) != 0) begin
      failures++;
      $display("FAIL reserved data=%h err=%b lat=%0d writes=%0d reads=%0d required data=0 err=1 lat=1 writes=0 reads=0",
               rd, re, lat, wr_pulses - w0, rd_pulses - r0);
    end
    send(2'b00, 6'd5, 6'd0, 16'h0000, 0, rd, re, lat);
    checks++;
    if (rd !== ref_mem[5] || re !== 1'b0) begin
      failures++;
      $display("FAIL reserved_next_load data=%h err=%b required data=%h err=0", rd, re, ref_mem[5]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic re; int lat;
    // LOAD, reset while in CAP
    req_op = 2'b00; req_addr = 6'd7; req_valid = 1'b1;
    @(posedge clk); #1;           // RD
    req_valid = 1'b0;
    @(posedge clk); #1;           // CAP
    reset = 1'b1;
    #1;
    checks++;
    if ({ram_read, ram_write, rsp_valid, req_ready} !== 4'b0001 || txn_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_in_cap rd/wr/rspv/ready=%b cnt=%0d required 0001 cnt=0", {ram_read, ram_write, rsp_valid, req_ready}, txn_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_txn = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_rsp rsp_valid=%b required 0", rsp_valid);
    end
    // STORE, reset while in WR: the write must not land
    req_op = 2'b01; req_addr = 6'd20; req_wdata = ~ref_mem[20]; req_valid = 1'b1;
    @(posedge clk); #1;           // WR
    req_valid = 1'b0;
    checks++;
    if (ram_write !== 1'b1) begin
      failures++;
      $display("FAIL store_wr_strobe ram_write=%b required 1", ram_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ram_write !== 1'b0 || ram_data_in !== 16'h0000) begin
      failures++;
      $display("FAIL reset_in_wr ram_write=%b data_in=%h required 0 and 0000", ram_write, ram_data_in);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send(2'b00, 6'd20, 6'd0, 16'h0000, 0, rd, re, lat);
    checks++;
    if (rd !== ref_mem[20] || txn_count !== exp_txn) begin
      failures++;
      $display("FAIL reset_wr_suppressed data=%h cnt=%0d required data=%h cnt=%0d", rd, txn_count, ref_mem[20], exp_txn);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic re; int lat; logic [15:0] wd; logic [5:0] a;
    for (int i = 0; i < 256; i++) begin
      wd = 16'($urandom);
      a  = 6'($urandom_range(0, 63));
      send(2'b01, a, 6'd0, wd, 0, rd, re, lat);
      ref_mem[a] = wd;
      checks++;
      if (rd !== wd || lat != 2 || txn_count !== exp_txn || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_store i=%0d data=%h lat=%0d cnt=%0d ready=%b required data=%h lat=2 cnt=%0d ready=1",
                 i, rd, lat, txn_count, req_ready, wd, exp_txn);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] rd; logic re; int lat; int w0; int r0;
    logic [1:0] op; logic [5:0] a; logic [5:0] d; logic [15:0] wd;
    logic [15:0] exp_d; logic exp_e; int exp_lat; int exp_w; int exp_r;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 6'($urandom_range(0, 63));
      d  = 6'($urandom_range(0, 63));
      wd = 16'($urandom);
      case (op)
        2'b00: begin exp_d = ref_mem[a]; exp_e = 1'b0; exp_lat = 3; exp_w = 0; exp_r = 1; end
        2'b01: begin exp_d = wd; exp_e = 1'b0; exp_lat = 2; exp_w = 1; exp_r = 0; ref_mem[a] = wd; end
        2'b10: begin exp_d = ref_mem[a]; exp_e = 1'b0; exp_lat = 4; exp_w = 1; exp_r = 1; ref_mem[d] = ref_mem[a]; end
        default: begin exp_d = 16'h0000; exp_e = 1'b1; exp_lat = 1; exp_w = 0; exp_r = 0; end
      endcase
      w0 = wr_pulses; r0 = rd_pulses;
      send(op, a, d, wd, $urandom_range(0, 2), rd, re, lat);
      checks++;
      if (rd !== exp_d || re !== exp_e || lat != exp_lat || (wr_pulses - w0) != exp_w ||
          (rd_pulses - r0) != exp_r || txn_count !== exp_txn) begin
        failures++;
        $display("FAIL random i=%0d op=%0d data=%h err=%b lat=%0d wr=%0d rd=%0d cnt=%0d required data=%h err=%b lat=%0d wr=%0d rd=%0d cnt=%0d",
                 i, op, rd, re, lat, wr_pulses - w0, rd_pulses - r0, txn_count,
                 exp_d, exp_e, exp_lat, exp_w, exp_r, exp_txn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_move();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
